pll_reset_sequencer: RTL and testbench



---
 rtl/pll_seq_pkg.sv | 26 ++
 rtl/pll_reset_sequencer_sync_2ff.sv | 26 ++
 rtl/pll_reset_sequencer.sv | 139 +++++++++++++
 tb/tb_pll_reset_sequencer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_seq_pkg.sv
// Shared definitions for the PLL reset sequencer: FSM state encodings,
// default timing constants for a 50 MHz reference clock, and helpers.
// Optional feature macro used by the top: PLL_SEQ_LOSS_CNT_EN.
package pll_seq_pkg;

    localparam int REFCLK_HZ         = 50_000_000;
    localparam int DEF_RST_CYCLES    = REFCLK_HZ / 5_000_000;  // 200 ns
    localparam int DEF_LOCK_TIMEOUT  = REFCLK_HZ / 1_000;      // 1 ms
    localparam int DEF_STABLE_CYCLES = 1024;                   // ~20.5 us
    localparam int DEF_MAX_RETRIES   = 3;
    localparam int DEF_CNT_W         = 17;

    typedef enum logic [2:0] {
        ST_RESET_PLL = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4
    } pll_state_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/pll_reset_sequencer_sync_2ff.sv
// Generic two-flop single-bit synchronizer. Both flops clear on the
// synchronous active-high rst so the synchronized value starts at 0.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_sync;

    // Two back-to-back flops; r_meta may go metastable, r_sync settles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: pulses the PLL reset, waits for lock, requires lock
// to hold for STABLE_CYCLES before releasing sys_rst, retries on timeout and
// latches FAULT after too many consecutive timeouts.
// Optional macro PLL_SEQ_LOSS_CNT_EN adds the loss_count output, a saturating
// count of RUN -> RESET_PLL transitions (lock lost while running).
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RST_CYCLES    = DEF_RST_CYCLES,
    parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int MAX_RETRIES   = DEF_MAX_RETRIES,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic       fault,
    output logic [1:0] retry_count,
    output logic [2:0] state
`ifdef PLL_SEQ_LOSS_CNT_EN
    ,
    output logic [7:0] loss_count
`endif
);

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [1:0]       RETRY_MAX   = 2'(MAX_RETRIES);

    logic             w_locked_s;
    pll_state_e       r_state;
    pll_state_e       w_state_nxt;
    logic [CNT_W-1:0] r_timer;
    logic [1:0]       r_retry;
    logic [1:0]       w_retry_nxt;
    logic             r_pll_rst;
    logic             r_sys_rst;
    logic             r_ready;
    logic             r_fault;

    sync_2ff u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .d   (pll_locked),
        .q   (w_locked_s)
    );

    // Next-state and retry bookkeeping; lock beats a coincident timeout.
    always_comb begin
        w_state_nxt = r_state;
        w_retry_nxt = r_retry;
        case (r_state)
            ST_RESET_PLL: begin
                if (r_timer == RST_LAST) w_state_nxt = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (w_locked_s) begin
                    w_state_nxt = ST_STABLE;
                end else if (r_timer == TIMEOUT_LAST) begin
                    if (r_retry == RETRY_MAX) begin
                        w_state_nxt = ST_FAULT;
                    end else begin
                        w_retry_nxt = r_retry + 2'd1;
                        w_state_nxt = ST_RESET_PLL;
                    end
                end
            end
            ST_STABLE: begin
                if (!w_locked_s)                w_state_nxt = ST_WAIT_LOCK;
                else if (r_timer == STABLE_LAST) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (!w_locked_s) w_state_nxt = ST_RESET_PLL;
            end
            ST_FAULT: begin
                w_state_nxt = ST_FAULT;
            end
            default: begin
                w_state_nxt = ST_RESET_PLL;
            end
        endcase
        if (w_state_nxt == ST_RUN) w_retry_nxt = 2'd0;
    end

    // State, timer and outputs; outputs decode the next state so they move
    // on the same edge as state. The timer is frozen in RUN and FAULT since
    // nothing there measures time, which keeps it from ever wrapping.
    always_ff @(posedge refclk) begin
        if (rst) begin
            r_state   <= ST_RESET_PLL;
            r_timer   <= '0;
            r_retry   <= 2'd0;
            r_pll_rst <= 1'b1;
            r_sys_rst <= 1'b1;
            r_ready   <= 1'b0;
            r_fault   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_retry <= w_retry_nxt;
            if (w_state_nxt != r_state) begin
                r_timer <= '0;
            end else if (r_state != ST_RUN && r_state != ST_FAULT) begin
                r_timer <= r_timer + CNT_W'(1);
            end
            r_pll_rst <= (w_state_nxt == ST_RESET_PLL) || (w_state_nxt == ST_FAULT);
            r_sys_rst <= (w_state_nxt != ST_RUN);
            r_ready   <= (w_state_nxt == ST_RUN);
            r_fault   <= (w_state_nxt == ST_FAULT);
        end
    end

`ifdef PLL_SEQ_LOSS_CNT_EN
    logic [7:0] r_loss_cnt;

    // Count lock losses while running; sticks at 255, cleared only by rst.
    always_ff @(posedge refclk) begin
        if (rst) begin
            r_loss_cnt <= 8'd0;
        end else if (r_state == ST_RUN && w_state_nxt == ST_RESET_PLL) begin
            r_loss_cnt <= sat_inc8(r_loss_cnt);
        end
    end

    assign loss_count = r_loss_cnt;
`endif

    assign pll_rst     = r_pll_rst;
    assign sys_rst     = r_sys_rst;
    assign ready       = r_ready;
    assign fault       = r_fault;
    assign retry_count = r_retry;
    assign state       = r_state;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench for pll_reset_sequencer with short timing parameters.
// Edge k is counted from the edge that samples rst high (k=0).
module tb_pll_reset_sequencer;

    localparam logic [2:0] S_RST  = 3'd0;
    localparam logic [2:0] S_WAIT = 3'd1;
    localparam logic [2:0] S_STAB = 3'd2;
    localparam logic [2:0] S_RUN  = 3'd3;
    localparam logic [2:0] S_FLT  = 3'd4;

    logic       refclk = 1'b0;
    logic       rst;
    logic       pll_locked;
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic       fault;
    logic [1:0] retry_count;
    logic [2:0] state;
`ifdef PLL_SEQ_LOSS_CNT_EN
    logic [7:0] loss_count;
`endif

    pll_reset_sequencer #(
        .RST_CYCLES    (4),
        .LOCK_TIMEOUT  (20),
        .STABLE_CYCLES (8),
        .MAX_RETRIES   (2),
        .CNT_W         (17)
    ) dut (
        .refclk      (refclk),
        .rst         (rst),
        .pll_locked  (pll_locked),
        .pll_rst     (pll_rst),
        .sys_rst     (sys_rst),
        .ready       (ready),
        .fault       (fault),
        .retry_count (retry_count),
        .state       (state)
`ifdef PLL_SEQ_LOSS_CNT_EN
        ,
        .loss_count  (loss_count)
`endif
    );

    always #10 refclk = ~refclk;

    typedef struct {
        int         cyc;
        string      nm;
        logic [2:0] st;
        logic [1:0] rc;
        logic [7:0] loss;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   base = 0;
    int   checks = 0;
    int   failures = 0;

    always @(posedge refclk) cyc <= cyc + 1;

    // Output vector implied by a state: {state, pll_rst, sys_rst, ready, fault, retry}
    function automatic logic [8:0] out_vec(input logic [2:0] st, input logic [1:0] rc);
        return {st, (st == S_RST) || (st == S_FLT), st != S_RUN, st == S_RUN, st == S_FLT, rc};
    endfunction

    task automatic push_exp(input int k, input string nm, input logic [2:0] st,
                            input logic [1:0] rc, input logic [7:0] loss);
        exp_t e;
        e.cyc = base + k; e.nm = nm; e.st = st; e.rc = rc; e.loss = loss;
        q.push_back(e);
    endtask

    task automatic at_edge(input int k);
        while (cyc < base + k) begin
            @(posedge refclk);
            #1;
        end
    endtask

    task automatic do_reset(input string nm);
        rst = 1'b1;
        @(posedge refclk);
        #1;
        rst  = 1'b0;
        base = cyc;
        push_exp(0, nm, S_RST, 2'd0, 8'd0);
    endtask

    // Monitor: compare queued expectations against the DUT away from the edge.
    always @(negedge refclk) begin : mon
        exp_t       e;
        logic [8:0] got;
        logic [8:0] want;
        logic [7:0] got_loss;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e    = q.pop_front();
            got  = {state, pll_rst, sys_rst, ready, fault, retry_count};
            want = out_vec(e.st, e.rc);
`ifdef PLL_SEQ_LOSS_CNT_EN
            got_loss = loss_count;
`else
            got_loss = e.loss;
`endif
            checks = checks + 1;
            if (e.cyc != cyc || got !== want || got_loss !== e.loss) begin
                failures = failures + 1;
                $display("FAIL %s at cyc %0d (due %0d): got st=%0d pll_rst=%b sys_rst=%b ready=%b fault=%b rc=%0d loss=%0d, want st=%0d pll_rst=%b sys_rst=%b ready=%b fault=%b rc=%0d loss=%0d",
                         e.nm, cyc, e.cyc, got[8:6], got[5], got[4], got[3], got[2], got[1:0], got_loss,
                         want[8:6], want[5], want[4], want[3], want[2], want[1:0], e.loss);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        pll_locked = 1'b0;
        repeat (2) @(posedge refclk);
        #1;

        // Nominal lock: locked sampled from edge 10, RUN at edge 20.
        do_reset("nom_reset");
        push_exp(1,  "nom_rst1",  S_RST,  2'd0, 8'd0);
        push_exp(3,  "nom_rst3",  S_RST,  2'd0, 8'd0);
        push_exp(4,  "nom_wait4", S_WAIT, 2'd0, 8'd0);
        push_exp(11, "nom_wait11", S_WAIT, 2'd0, 8'd0);
        push_exp(12, "nom_stab12", S_STAB, 2'd0, 8'd0);
        push_exp(19, "nom_stab19", S_STAB, 2'd0, 8'd0);
        push_exp(20, "nom_run20", S_RUN,  2'd0, 8'd0);
        push_exp(22, "nom_run22", S_RUN,  2'd0, 8'd0);
        at_edge(9);  pll_locked = 1'b1;
        at_edge(23);
        checks = checks + 1;
        if (state !== S_RUN || sys_rst !== 1'b0 || ready !== 1'b1) begin
            failures = failures + 1;
            $display("FAIL nom_direct23: st=%0d sys_rst=%b ready=%b", state, sys_rst, ready);
        end

        // Unstable lock: high edges 6-10, low 11-13, high from 14.
        pll_locked = 1'b0;
        do_reset("unst_reset");
        push_exp(8,  "unst_stab8",  S_STAB, 2'd0, 8'd0);
        push_exp(12, "unst_stab12", S_STAB, 2'd0, 8'd0);
        push_exp(13, "unst_drop13", S_WAIT, 2'd0, 8'd0);
        push_exp(15, "unst_wait15", S_WAIT, 2'd0, 8'd0);
        push_exp(16, "unst_stab16", S_STAB, 2'd0, 8'd0);
        push_exp(23, "unst_stab23", S_STAB, 2'd0, 8'd0);
        push_exp(24, "unst_run24",  S_RUN,  2'd0, 8'd0);
        at_edge(5);  pll_locked = 1'b1;
        at_edge(10); pll_locked = 1'b0;
        at_edge(13); pll_locked = 1'b1;
        at_edge(25);
        checks = checks + 1;
        if (state !== S_RUN || retry_count !== 2'd0) begin
            failures = failures + 1;
            $display("FAIL unst_direct25: st=%0d rc=%0d", state, retry_count);
        end

        // Lock loss in RUN, twice.
        pll_locked = 1'b0;
        do_reset("loss_reset");
        push_exp(20, "loss_run20",  S_RUN,  2'd0, 8'd0);
        push_exp(26, "loss_run26",  S_RUN,  2'd0, 8'd0);
        push_exp(27, "loss_rst27",  S_RST,  2'd0, 8'd1);
        push_exp(30, "loss_rst30",  S_RST,  2'd0, 8'd1);
        push_exp(31, "loss_wait31", S_WAIT, 2'd0, 8'd1);
        push_exp(35, "loss_stab35", S_STAB, 2'd0, 8'd1);
        push_exp(42, "loss_stab42", S_STAB, 2'd0, 8'd1);
        push_exp(43, "loss_run43",  S_RUN,  2'd0, 8'd1);
        push_exp(48, "loss_rst48",  S_RST,  2'd0, 8'd2);
        at_edge(9);  pll_locked = 1'b1;
        at_edge(24); pll_locked = 1'b0;
        at_edge(32); pll_locked = 1'b1;
        at_edge(45); pll_locked = 1'b0;
        at_edge(49);
        checks = checks + 1;
        if (state !== S_RST || pll_rst !== 1'b1 || sys_rst !== 1'b1 || ready !== 1'b0) begin
            failures = failures + 1;
            $display("FAIL loss_direct49: st=%0d pll_rst=%b sys_rst=%b ready=%b",
                     state, pll_rst, sys_rst, ready);
        end

        // Lock arrives on the cycle the second wait window times out.
        pll_locked = 1'b0;
        do_reset("sim_reset");
        push_exp(23, "sim_wait23", S_WAIT, 2'd0, 8'd0);
        push_exp(24, "sim_retry24", S_RST, 2'd1, 8'd0);
        push_exp(28, "sim_wait28", S_WAIT, 2'd1, 8'd0);
        push_exp(47, "sim_wait47", S_WAIT, 2'd1, 8'd0);
        push_exp(48, "sim_stab48", S_STAB, 2'd1, 8'd0);
        push_exp(55, "sim_stab55", S_STAB, 2'd1, 8'd0);
        push_exp(56, "sim_run56",  S_RUN,  2'd0, 8'd0);
        at_edge(45); pll_locked = 1'b1;
        at_edge(57);
        checks = checks + 1;
        if (state !== S_RUN || retry_count !== 2'd0) begin
            failures = failures + 1;
            $display("FAIL sim_direct57: st=%0d rc=%0d", state, retry_count);
        end

        // Reset while in STABLE, then restart with lock already present.
        pll_locked = 1'b0;
        do_reset("rs_reset");
        push_exp(12, "rs_stab12", S_STAB, 2'd0, 8'd0);
        push_exp(14, "rs_stab14", S_STAB, 2'd0, 8'd0);
        at_edge(9);  pll_locked = 1'b1;
        at_edge(14);
        do_reset("rs_midreset");
        push_exp(3,  "rs_rst3",   S_RST,  2'd0, 8'd0);
        push_exp(4,  "rs_wait4",  S_WAIT, 2'd0, 8'd0);
        push_exp(5,  "rs_stab5",  S_STAB, 2'd0, 8'd0);
        push_exp(12, "rs_stab12b", S_STAB, 2'd0, 8'd0);
        push_exp(13, "rs_run13",  S_RUN,  2'd0, 8'd0);
        at_edge(14);

        // Timeouts to FAULT; fault holds even after lock appears.
        pll_locked = 1'b0;
        do_reset("to_reset");
        push_exp(23, "to_wait23", S_WAIT, 2'd0, 8'd0);
        push_exp(24, "to_rst24",  S_RST,  2'd1, 8'd0);
        push_exp(27, "to_rst27",  S_RST,  2'd1, 8'd0);
        push_exp(28, "to_wait28", S_WAIT, 2'd1, 8'd0);
        push_exp(47, "to_wait47", S_WAIT, 2'd1, 8'd0);
        push_exp(48, "to_rst48",  S_RST,  2'd2, 8'd0);
        push_exp(51, "to_rst51",  S_RST,  2'd2, 8'd0);
        push_exp(52, "to_wait52", S_WAIT, 2'd2, 8'd0);
        push_exp(71, "to_wait71", S_WAIT, 2'd2, 8'd0);
        push_exp(72, "to_fault72", S_FLT, 2'd2, 8'd0);
        push_exp(90, "to_fault90", S_FLT, 2'd2, 8'd0);
        push_exp(100, "to_fault100", S_FLT, 2'd2, 8'd0);
        at_edge(80); pll_locked = 1'b1;
        at_edge(100);
        checks = checks + 1;
        if (state !== S_FLT || fault !== 1'b1 || pll_rst !== 1'b1 || retry_count !== 2'd2) begin
            failures = failures + 1;
            $display("FAIL to_direct100: st=%0d fault=%b pll_rst=%b rc=%0d",
                     state, fault, pll_rst, retry_count);
        end

        // Reset out of FAULT restarts the sequence.
        pll_locked = 1'b0;
        do_reset("flt_reset");
        push_exp(3, "flt_rst3",  S_RST,  2'd0, 8'd0);
        push_exp(4, "flt_wait4", S_WAIT, 2'd0, 8'd0);
        at_edge(6);
        checks = checks + 1;
        if (state !== S_WAIT || fault !== 1'b0 || retry_count !== 2'd0) begin
            failures = failures + 1;
            $display("FAIL flt_direct6: st=%0d fault=%b rc=%0d", state, fault, retry_count);
        end

        repeat (2) @(posedge refclk);
        #1;
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            checks = checks + 1;
            failures = failures + 1;
            $display("FAIL %s: never compared, got no sample, want check at cyc %0d", e.nm, e.cyc);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
